// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator and receiver paths.
// Receiver FSM state encoding, idle line level and the parity helper.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic PARITY_IDLE_LEVEL = 1'b1;
    localparam int   PARITY_MAX_W      = 16;

    // Callers zero-extend narrower words; zero padding leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_rx.sv
// Serial start/data/parity/stop receiver with parity check; stop-bit check under PARITY_RX_FRAME_ERR_EN.
// Latency: outputs registered on the edge sampling the stop bit; data_valid is a 1-cycle pulse.
// Backpressure: none; bit_en qualifies sampling and the consumer must take the word on data_valid.
module parity_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
`ifdef PARITY_RX_FRAME_ERR_EN
            frame_err  <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (serial_in != PARITY_IDLE_LEVEL) begin
                            count <= '0;
                            shreg <= '0;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        // Right shift: after DATA_W bits the first bit received sits at bit 0.
                        shreg <= {serial_in, shreg[DATA_W-1:1]};
                        count <= count + 1'b1;
                        if (count == CNT_W'(DATA_W - 1))
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= serial_in;
                        state   <= STOP;
                    end
                    STOP: begin
                        data_out   <= shreg;
                        parity_err <= par_bit != calc_parity(PARITY_MAX_W'(shreg), ODD_PARITY);
`ifdef PARITY_RX_FRAME_ERR_EN
                        frame_err  <= ~serial_in;
`endif
                        data_valid <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef PARITY_RX_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: hand-computed frames, gaps, errors, reset abort, back-to-back.
module tb_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       bit_en = 1'b0;
    logic [3:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = 0;
    int prev_pulse = 0;
    int p0;

    parity_rx #(.DATA_W(4), .ODD_PARITY(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            pulses     <= pulses + 1;
            prev_pulse <= last_pulse;
            last_pulse <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        serial_in = b;
        bit_en    = 1'b1;
        @(posedge clk); #1;
        bit_en    = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par, input logic stp, input int max_gap);
        send_bit(1'b0, $urandom_range(0, max_gap));
        for (int i = 0; i < 4; i++) send_bit(d[i], $urandom_range(0, max_gap));
        send_bit(par, $urandom_range(0, max_gap));
        send_bit(stp, 0);
        serial_in = 1'b1;
    endtask

    task automatic settle();
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic exp_ferr;
        #12;
        check("rst_data_out", data_out, 4'h0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4'hA, parity 0, bit_en continuous
        p0 = pulses;
        send_frame(4'hA, 1'b0, 1'b1, 0);
        settle();
        check("a_data", data_out, 4'hA);
        check("a_pulses", pulses - p0, 1);
        check("a_perr", parity_err, 1'b0);
        check("a_ferr", frame_err, 1'b0);

        // 4'hB, parity 1, random gaps
        p0 = pulses;
        send_frame(4'hB, 1'b1, 1'b1, 5);
        settle();
        check("b_data", data_out, 4'hB);
        check("b_pulses", pulses - p0, 1);
        check("b_perr", parity_err, 1'b0);

        // 4'hE with wrong parity 0
        p0 = pulses;
        send_frame(4'hE, 1'b0, 1'b1, 2);
        settle();
        check("e_data", data_out, 4'hE);
        check("e_pulses", pulses - p0, 1);
        check("e_perr", parity_err, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("e_perr_held", parity_err, 1'b1);
        check("e_valid_low", data_valid, 1'b0);

        // 4'h9, parity 0, bad stop bit
`ifdef PARITY_RX_FRAME_ERR_EN
        exp_ferr = 1'b1;
`else
        exp_ferr = 1'b0;
`endif
        p0 = pulses;
        send_frame(4'h9, 1'b0, 1'b0, 1);
        settle();
        check("9_data", data_out, 4'h9);
        check("9_pulses", pulses - p0, 1);
        check("9_perr", parity_err, 1'b0);
        check("9_ferr", frame_err, exp_ferr);

        // Reset after two data bits, then 4'hF parity 0
        p0 = pulses;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_data_cleared", data_out, 4'h0);
        #2 rst_n = 1'b1;
        settle();
        check("abort_pulses", pulses - p0, 0);
        p0 = pulses;
        send_frame(4'hF, 1'b0, 1'b1, 0);
        settle();
        check("f_data", data_out, 4'hF);
        check("f_pulses", pulses - p0, 1);
        check("f_perr", parity_err, 1'b0);
        check("f_ferr", frame_err, 1'b0);

        // Idle line with bit_en high, then back-to-back 4'h0 and 4'h8
        p0 = pulses;
        serial_in = 1'b1;
        bit_en = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        bit_en = 1'b0;
        check("idle_pulses", pulses - p0, 0);
        send_frame(4'h0, 1'b0, 1'b1, 0);
        check("bb0_data", data_out, 4'h0);
        check("bb0_perr", parity_err, 1'b0);
        send_frame(4'h8, 1'b1, 1'b1, 0);
        settle();
        check("bb_pulses", pulses - p0, 2);
        check("bb_spacing", last_pulse - prev_pulse, 7);
        check("bb8_data", data_out, 4'h8);
        check("bb8_perr", parity_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
